beeb_video_ula: RTL

Video ULA for the BBC Micro core; sits directly downstream of the 6845 CRTC. It divides the 16 MHz pixel clock into the CRTC character clock enables and serialises screen-RAM bytes into pixels. Each pixel passes through a 16-entry palette with flash, cursor overlay and DE blanking before leaving as 1-bit R/G/B. In teletext mode it passes the external SAA5050 RGB through instead.

---
 rtl/beeb_video_pkg.sv | 24 ++
 rtl/beeb_video_ula_if.sv | 11 +
 rtl/beeb_vidula_palette.sv | 28 ++
 rtl/beeb_video_ula.sv | 125 ++++++++++++
 4 files changed

// File: rtl/beeb_video_pkg.sv
// rtl/beeb_video_pkg.sv - shared constants and types for the BBC Micro video ULA
package beeb_video_pkg;

    localparam int CTRL_CUR0   = 7;
    localparam int CTRL_CUR1   = 6;
    localparam int CTRL_CUR2   = 5;
    localparam int CTRL_CRTC2M = 4;
    localparam int CTRL_RATE   = 2;
    localparam int CTRL_TTX    = 1;
    localparam int CTRL_FLASH  = 0;

    localparam logic [1:0] RATE_2M  = 2'b00;
    localparam logic [1:0] RATE_4M  = 2'b01;
    localparam logic [1:0] RATE_8M  = 2'b10;
    localparam logic [1:0] RATE_16M = 2'b11;

    typedef logic [3:0] pal_entry_t;

    // Logical colour index taken from the odd bit positions of the shifter.
    function automatic logic [3:0] pixel_index(input logic [7:0] sr);
        return {sr[7], sr[5], sr[3], sr[1]};
    endfunction

endpackage

// File: rtl/beeb_video_ula_if.sv
// rtl/beeb_video_ula_if.sv - CPU register bus into the video ULA
interface beeb_video_ula_if;
    logic       ENABLE;
    logic       nCS;
    logic       R_nW;
    logic       A0;
    logic [7:0] CPU_DI;

    modport master (output ENABLE, output nCS, output R_nW, output A0, output CPU_DI);
    modport slave  (input  ENABLE, input  nCS, input  R_nW, input  A0, input  CPU_DI);
endinterface

// File: rtl/beeb_vidula_palette.sv
// rtl/beeb_vidula_palette.sv - 16x4 palette register file, sync write, async read
module beeb_vidula_palette
    import beeb_video_pkg::*;
(
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       we,
    input  logic [3:0] waddr,
    input  pal_entry_t wdata,
    input  logic [3:0] raddr,
    output pal_entry_t rdata
);

    pal_entry_t pal [16];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) begin
                pal[i] <= '0;
            end
        end else if (we) begin
            pal[waddr] <= wdata;
        end
    end

    assign rdata = pal[raddr];

endmodule

// File: rtl/beeb_video_ula.sv
// rtl/beeb_video_ula.sv - video ULA: CRTC clock divider, pixel shifter, palette, cursor
module beeb_video_ula
    import beeb_video_pkg::*;
(
    input  logic             CLOCK,
    input  logic             RESET,
    beeb_video_ula_if.slave  cpu,
    output logic             CRTC_CLKEN,
    output logic             CRTC_nCLKEN,
    input  logic             DE,
    input  logic             CURSOR,
    input  logic [7:0]       VID_DI,
    input  logic [2:0]       TTX_RGB,
    output logic             TELETEXT,
    output logic             R,
    output logic             G,
    output logic             B
);

    logic [7:0] ctrl;
    logic [3:0] cnt;
    logic [7:0] sr;
    logic       de_r;
    logic       cact;
    logic [1:0] cseg;

    logic       wr;
    logic       sh;
    logic       cur_mask;
    pal_entry_t pe;
    logic [2:0] colour;
    logic [2:0] base;

    assign wr       = cpu.ENABLE & ~cpu.nCS & ~cpu.R_nW;
    assign TELETEXT = ctrl[CTRL_TTX];

    beeb_vidula_palette u_palette (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .we    (wr & cpu.A0),
        .waddr (cpu.CPU_DI[7:4]),
        .wdata (cpu.CPU_DI[3:0]),
        .raddr (pixel_index(sr)),
        .rdata (pe)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ctrl <= '0;
        end else if (wr && !cpu.A0) begin
            ctrl <= cpu.CPU_DI;
        end
    end

    // Enables decode the live cnt/ctrl so a CRTC rate change never adds a pulse.
    always_comb begin
        CRTC_CLKEN  = 1'b0;
        CRTC_nCLKEN = 1'b0;
        if (ctrl[CTRL_CRTC2M]) begin
            CRTC_CLKEN  = (cnt[2:0] == 3'd7);
            CRTC_nCLKEN = (cnt[2:0] == 3'd3);
        end else begin
            CRTC_CLKEN  = (cnt == 4'd15);
            CRTC_nCLKEN = (cnt == 4'd7);
        end
    end

    always_comb begin
        sh = 1'b0;
        case (ctrl[CTRL_RATE +: 2])
            RATE_16M: sh = 1'b1;
            RATE_8M:  sh = cnt[0];
            RATE_4M:  sh = &cnt[1:0];
            default:  sh = &cnt[2:0];
        endcase
    end

    always_comb begin
        cur_mask = 1'b0;
        if (cact) begin
            case (cseg)
                2'd0:    cur_mask = ctrl[CTRL_CUR0];
                2'd1:    cur_mask = ctrl[CTRL_CUR1];
                default: cur_mask = ctrl[CTRL_CUR2];
            endcase
        end
    end

    // Palette stores BGR inverted; flash flips the whole entry when enabled.
    always_comb begin
        colour = ~pe[2:0] ^ {3{pe[3] & ctrl[CTRL_FLASH]}};
        base   = ctrl[CTRL_TTX] ? TTX_RGB : (de_r ? colour : 3'b000);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt       <= '0;
            sr        <= 8'hFF;
            de_r      <= 1'b0;
            cact      <= 1'b0;
            cseg      <= '0;
            {B, G, R} <= 3'b000;
        end else begin
            cnt       <= cnt + 4'd1;
            {B, G, R} <= base ^ {3{cur_mask}};
            if (CRTC_CLKEN) begin
                sr   <= VID_DI;
                de_r <= DE;
                if (CURSOR) begin
                    cact <= 1'b1;
                    cseg <= '0;
                end else if (cact) begin
                    cseg <= cseg + 2'd1;
                    if (cseg == 2'd3) begin
                        cact <= 1'b0;
                    end
                end
            end else if (sh) begin
                // Ones fill behind the data so an exhausted byte reads as index 15.
                sr <= {sr[6:0], 1'b1};
            end
        end
    end

endmodule
